// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch at a time, returns the addressed word
// after WAIT wait states. Define IMEM_ALIGN_CHECK_EN to fault misaligned requests/loads.
module imem_responder #(
  parameter int SIZE = 64,
  parameter int WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_fault,
  input  logic        load_en,
  input  logic [63:0] load_addr,
  input  logic [31:0] load_data
);
  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic        fault;
    logic [31:0] instr;
  } rsp_t;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [63:0]   addr_q;
  rsp_t          rsp_q;
  logic [31:0]   mem [SIZE];
  logic [IW-1:0] req_idx, load_idx;
  logic          req_bad, load_bad, accept;

  // Address is unusable if it lies past the array or (optionally) is not word aligned.
  function automatic logic addr_bad(input logic [63:0] a);
    logic bad;
    bad = |(a >> (IW + 2));
    if (SIZE < (1 << IW)) bad = bad | (int'(a[IW+1:2]) >= SIZE);
`ifdef IMEM_ALIGN_CHECK_EN
    bad = bad | (|a[1:0]);
`else
    bad = bad | 1'b0;
`endif
    return bad;
  endfunction

  assign req_idx  = addr_q[IW+1:2];
  assign load_idx = load_addr[IW+1:2];
  assign req_bad  = addr_bad(addr_q);
  assign load_bad = addr_bad(load_addr);

  assign req_ready = (state == ST_IDLE) && !flush && !reset;
  assign accept    = req_valid && req_ready;

  assign rsp_valid = (state == ST_RESP);
  assign rsp_instr = rsp_q.instr;
  assign rsp_fault = rsp_q.fault;

  // WAIT=0 still spends one registered cycle so latency is uniformly WAIT+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      addr_q <= 64'd0;
      rsp_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q <= req_addr;
            cnt    <= 4'(WAIT);
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (flush) begin
            cnt   <= 4'd0;
            state <= ST_IDLE;
          end else if (cnt == 4'd0) begin
            rsp_q.fault <= req_bad;
            rsp_q.instr <= req_bad ? 32'h0 : mem[req_idx];
            state       <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (flush || rsp_ready) begin
            rsp_q <= '0;
            state <= ST_IDLE;
          end
        end
        default: begin
          rsp_q <= '0;
          cnt   <= 4'd0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Array is never reset; a load landing on the response edge is seen only by later reads.
  always_ff @(posedge clk) begin
    if (!reset && load_en && !load_bad) mem[load_idx] <= load_data;
  end
endmodule
